signal_history_reader: RTL
==========================

SIGNAL_HISTORY_READER -- requirements
Module: signal_history_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of the tracked signal.
REQ-002 SHALL have parameter DEPTH, default 8, number of history entries, a power of two no smaller than 2.
REQ-003 SHALL have parameter POST_COUNT, default 4, number of samples captured after a trigger before freezing, range 0..DEPTH-1.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_in  input  WIDTH  tracked signal value.
REQ-007 SHALL have port sample_en  input  1  write sample_in into the history this cycle.
REQ-008 SHALL have port trigger  input  1  start the post-trigger capture.
REQ-009 SHALL have port freeze_clr  input  1  leave FROZEN and resume capture.
REQ-010 SHALL have port rd_req  input  1  read request.
REQ-011 SHALL have port rd_age  input  log2(DEPTH)  age of the requested entry (0 = newest).
REQ-012 SHALL have port rd_ack  output  1  response valid pulse.
REQ-013 SHALL have port rd_data  output  WIDTH  requested history entry.
REQ-014 SHALL have port rd_err  output  1  requested age not yet populated.
REQ-015 SHALL have port fill  output  log2(DEPTH)+1  number of valid entries.
REQ-016 SHALL have port frozen  output  1  high in the FROZEN state.
REQ-017 SHALL have port changed  output  1  pulse when a written sample differs from the newest entry.

Function
REQ-018 SHALL implement a circular buffer of DEPTH entries, indexed by write pointer wr_ptr.
REQ-019 SHALL, when sample_en=1 and the state is not FROZEN, write sample_in at wr_ptr and advance wr_ptr modulo DEPTH (wrap from DEPTH-1 to 0).
REQ-020 SHALL, on each accepted write, increment fill and saturate it at DEPTH.
REQ-021 SHALL drop writes while FROZEN: buffer, wr_ptr and fill are unchanged.
REQ-022 SHALL implement the state machine RUN -> ARMED on trigger=1.
REQ-023 SHALL move ARMED -> FROZEN when the post-trigger counter reaches POST_COUNT.
REQ-024 SHALL move FROZEN -> RUN on freeze_clr=1.
REQ-025 SHALL go directly from RUN to FROZEN on trigger when POST_COUNT=0.
REQ-026 SHALL clear the post-trigger counter on entry to ARMED.
REQ-027 SHALL increment the post-trigger counter on each accepted write in ARMED.
REQ-028 SHALL ignore trigger while in ARMED or FROZEN.
REQ-029 SHALL have freeze_clr win when trigger and freeze_clr are both high in FROZEN: go to RUN and do not arm.
REQ-030 SHALL ignore freeze_clr outside FROZEN.
REQ-031 SHALL preserve buffer contents and fill across FROZEN -> RUN.
REQ-032 SHALL, one cycle after rd_req=1, assert rd_ack for exactly one cycle.
REQ-033 SHALL drive rd_data with the entry at index (wr_ptr-1-rd_age) mod DEPTH, sampled with the request-cycle wr_ptr and buffer contents.
REQ-034 SHALL ensure a write in the same cycle as a request does not affect that response.
REQ-035 SHALL accept back-to-back rd_req every cycle and answer each one.
REQ-036 SHALL, when rd_age >= fill, assert rd_err with rd_ack and drive rd_data to 0.
REQ-037 SHALL otherwise hold rd_err low.
REQ-038 SHALL serve reads in all states.
REQ-039 SHALL, one cycle after an accepted write with fill>=1, pulse changed when sample_in differs from the prior newest entry.
REQ-040 SHALL never pulse changed for the first write after reset.
REQ-041 SHALL hold rd_data at its last value when rd_ack is low.

Reset
REQ-042 SHALL, while reset=1, force state RUN.
REQ-043 SHALL, while reset=1, force wr_ptr=0, fill=0 and the post-trigger counter to 0.
REQ-044 SHALL, while reset=1, force rd_ack=0, rd_err=0, rd_data=0, changed=0 and frozen=0.
REQ-045 SHALL leave buffer storage uninitialised by reset, since it is unreadable until fill covers it.
REQ-046 SHALL, on reset asserted mid-ARMED or mid-read, drop the pending response and return to RUN on the next edge.

Verification
REQ-047 SHALL verify: write 0x0001..0x000A with sample_en, then read ages 0,1,7 -> rd_data 0x000A, 0x0009, 0x0003; fill=8; no rd_err.
REQ-048 SHALL verify: after reset, write 0x1111, 0x2222, then read age 2 -> rd_ack=1, rd_err=1, rd_data=0.
REQ-049 SHALL verify: write 0x0005 while reading age 0 in the same cycle, with newest entry 0x0004 -> rd_data 0x0004; a read next cycle returns 0x0005.
REQ-050 SHALL verify: trigger then 6 writes (POST_COUNT=4) -> frozen rises after the 4th write; writes 5-6 are dropped; age 0 equals the 4th value.
REQ-051 SHALL verify: trigger and freeze_clr both high in FROZEN -> state RUN, frozen=0; the next write is accepted and no freeze follows.
REQ-052 SHALL verify: writes 0x00AA, 0x00AA, 0x00BB -> changed pulses only after the third write; reset mid-ARMED -> frozen=0, fill=0.

Source files
------------

// File: rtl/signal_history_reader.sv
// Signal history reader: circular capture buffer with trigger/freeze control
// and a fixed one-cycle read port addressed by sample age.
module signal_history_reader #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned POST_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     sample_en,
    input  logic                     trigger,
    input  logic                     freeze_clr,
    input  logic                     rd_req,
    input  logic [$clog2(DEPTH)-1:0] rd_age,
    output logic                     rd_ack,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_err,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     frozen,
    output logic                     changed
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    post_cnt;
    logic [AW-1:0]    post_cnt_d;
    logic             wr_acc;
    logic [AW-1:0]    newest_idx;
    logic [AW-1:0]    rd_idx;
    logic             rd_miss;

    // Write qualification and read/newest address arithmetic (wraps mod DEPTH)
    always_comb begin
        wr_acc     = sample_en && (state_q != ST_FROZEN);
        newest_idx = wr_ptr - AW'(1);
        rd_idx     = wr_ptr - AW'(1) - rd_age;
        rd_miss    = ({1'b0, rd_age} >= fill);
    end

    // Next-state and post-trigger counter logic
    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt;
        case (state_q)
            ST_RUN: begin
                if (trigger) begin
                    post_cnt_d = '0;
                    if (POST_COUNT == 0) begin
                        state_d = ST_FROZEN;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (wr_acc) begin
                    post_cnt_d = post_cnt + AW'(1);
                    if (({1'b0, post_cnt} + (AW+1)'(1)) == (AW+1)'(POST_COUNT)) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
            ST_FROZEN: begin
                if (freeze_clr) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control state, pointers, and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            post_cnt <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            frozen   <= 1'b0;
            changed  <= 1'b0;
            rd_ack   <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            state_q  <= state_d;
            post_cnt <= post_cnt_d;
            frozen   <= (state_d == ST_FROZEN);
            changed  <= wr_acc && (fill != '0) && (sample_in != mem[newest_idx]);
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill != (AW+1)'(DEPTH)) begin
                    fill <= fill + (AW+1)'(1);
                end
            end
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_err  <= rd_miss;
                rd_data <= rd_miss ? '0 : mem[rd_idx];
            end else begin
                rd_err  <= 1'b0;
            end
        end
    end

    // History storage; contents are only readable once fill covers them
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr] <= sample_in;
        end
    end

endmodule
